// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Index width for the default master count; the top derives its own from NUM_MASTERS
  localparam int unsigned DEFAULT_NUM_MASTERS = 2;
  localparam int unsigned IDX_W               = $clog2(DEFAULT_NUM_MASTERS);

  // Width of the outstanding-access counter (max 15 in flight)
  localparam int unsigned OUTSTANDING_W = 4;

  // Bits needed to hold values 0..max_val, at least one bit
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] winner
);

  // Scan indices above 'last' first, then wrap to the bottom of the vector
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i > int'(last))) begin
        valid  = 1'b1;
        winner = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i <= int'(last))) begin
        valid  = 1'b1;
        winner = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone N:1 round-robin arbiter with cycle-granular grants and a slave watchdog.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_cyc,
  input  logic [NUM_MASTERS-1:0]              m_stb,
  input  logic [NUM_MASTERS-1:0]              m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]              m_stall,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [NUM_MASTERS-1:0]              m_err,
  output logic [DATA_WIDTH-1:0]               m_rdata,
  output logic                                s_cyc,
  output logic                                s_stb,
  output logic                                s_we,
  output logic [ADDR_WIDTH-1:0]               s_addr,
  output logic [DATA_WIDTH-1:0]               s_wdata,
  output logic [DATA_WIDTH/8-1:0]             s_sel,
  input  logic                                s_stall,
  input  logic                                s_ack,
  input  logic                                s_err,
  input  logic [DATA_WIDTH-1:0]               s_rdata,
  output logic [$clog2(NUM_MASTERS)-1:0]      grant_idx,
  output logic                                busy
);

  localparam int unsigned IW    = $clog2(NUM_MASTERS);
  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned WD_W  = cnt_w(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic            WD_EN    = (TIMEOUT_CYCLES != 0);

  arb_state_e               state_q, state_d;
  logic [IW-1:0]            grant_idx_q, grant_idx_d;
  logic [IW-1:0]            last_q, last_d;
  logic                     busy_q, busy_d;
  logic [OUTSTANDING_W-1:0] out_q, out_d;
  logic [WD_W-1:0]          wd_q, wd_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          g_cyc, g_stb;
  logic          accept, resp, wd_fire;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_MASTERS];
  logic [SEL_W-1:0]      sel_a   [NUM_MASTERS];

  // Unflatten the per-master payload buses
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign sel_a[i]   = m_sel[i*SEL_W +: SEL_W];
  end

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req    (m_cyc),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Bus routing: granted master passes straight through, everyone else is stalled
  always_comb begin
    g_cyc   = m_cyc[grant_idx_q];
    g_stb   = m_stb[grant_idx_q];
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_sel   = '0;
    m_stall = '1;
    m_ack   = '0;
    m_err   = '0;
    m_rdata = s_rdata;
    case (state_q)
      ST_GRANT: begin
        s_cyc                = g_cyc;
        s_stb                = g_cyc & g_stb;
        s_we                 = m_we[grant_idx_q];
        s_addr               = addr_a[grant_idx_q];
        s_wdata              = wdata_a[grant_idx_q];
        s_sel                = sel_a[grant_idx_q];
        m_stall[grant_idx_q] = s_stall;
        m_ack[grant_idx_q]   = s_ack;
        m_err[grant_idx_q]   = s_err;
      end
      ST_ABORT: begin
        m_err[grant_idx_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, arbitration and watchdog bookkeeping
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_d      = last_q;
    out_d       = out_q;
    wd_d        = wd_q;
    accept      = s_stb & ~s_stall;
    resp        = (state_q == ST_GRANT) & (s_ack | s_err);
    wd_fire     = WD_EN && (wd_q == WD_LIMIT) && !resp;
    case (state_q)
      ST_IDLE: begin
        out_d = '0;
        wd_d  = '0;
        if (pick_valid) begin
          grant_idx_d = pick_idx;
          last_d      = pick_idx;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept && !resp && (out_q != '1)) begin
          out_d = out_q + OUTSTANDING_W'(1);
        end else if (resp && !accept && (out_q != '0)) begin
          out_d = out_q - OUTSTANDING_W'(1);
        end
        // A response always wins over the timeout on the same cycle
        if (resp || ((out_q == '0) && !accept)) begin
          wd_d = '0;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WD_W'(1);
        end
        if (!g_cyc) begin
          state_d = ST_IDLE;
          out_d   = '0;
          wd_d    = '0;
        end else if (wd_fire) begin
          state_d = ST_ABORT;
          out_d   = '0;
          wd_d    = '0;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        out_d   = '0;
        wd_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and pointer registers; pointer resets so master 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      last_q      <= IW'(NUM_MASTERS - 1);
      busy_q      <= 1'b0;
      out_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      wd_q        <= wd_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign busy      = busy_q;

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone slave port among NUM_MASTERS Wishbone masters.
- Round-robin arbitration at cycle (cyc) granularity. The grant is held for the whole bus cycle of the winning master.
- Includes a per-cycle watchdog that terminates a hung slave access with err.
- Sits between the bench/CPU-side masters and the register/peripheral slave in the simulation and integration tops.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- DATA_WIDTH, 32, data bus width; sel width is DATA_WIDTH/8.
- ADDR_WIDTH, 32, address bus width.
- TIMEOUT_CYCLES, 255, max cycles an accepted strobe may wait for ack/err before the watchdog fires; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_cyc  in  NUM_MASTERS  per-master cyc.
- m_stb  in  NUM_MASTERS  per-master stb.
- m_we  in  NUM_MASTERS  per-master we.
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i at slice i.
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  flattened write data.
- m_sel  in  NUM_MASTERS*DATA_WIDTH/8  flattened byte selects.
- m_stall  out  NUM_MASTERS  per-master stall.
- m_ack  out  NUM_MASTERS  per-master ack.
- m_err  out  NUM_MASTERS  per-master err.
- m_rdata  out  DATA_WIDTH  read data, broadcast to all masters.
- s_cyc, s_stb, s_we  out  1  slave-side control.
- s_addr  out  ADDR_WIDTH  slave address.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_sel  out  DATA_WIDTH/8  slave byte selects.
- s_stall, s_ack, s_err  in  1  slave responses.
- s_rdata  in  DATA_WIDTH  slave read data.
- grant_idx  out  $clog2(NUM_MASTERS)  index of the granted master (debug/monitor).
- busy  out  1  high while any master holds the grant.

Behaviour:
- Reset (async, rst=1), all outputs forced to:
  - s_cyc=0, s_stb=0, m_ack=0, m_err=0, busy=0, grant_idx=0.
  - m_stall = all ones.
  - Round-robin pointer last=NUM_MASTERS-1, so master 0 has top priority after reset.
  - Watchdog counter = 0.
- State machine, IDLE / GRANT / ABORT:
  - IDLE: if any m_cyc[i]=1, pick the first requester scanning (last+1) mod N upward with wrap-around. Register it into grant_idx, set last=grant_idx, go to GRANT. Arbitration latency is 1 cycle: the winner is routed on the cycle after its cyc is first seen.
  - GRANT: s_* outputs are combinational copies of the granted master's m_*.
    - m_stall[g]=s_stall, m_ack[g]=s_ack, m_err[g]=s_err.
    - Non-granted masters: stall=1, ack=0, err=0.
    - m_rdata = s_rdata, unconditionally.
  - GRANT exit: when m_cyc[g] falls, s_cyc drops in the same cycle (combinational) and the FSM returns to IDLE. Minimum one idle cycle between grants; no back-to-back handover.
  - ABORT: entered when the watchdog fires.
    - s_cyc=0 and s_stb=0.
    - m_err[g]=1 for exactly one cycle; m_stall[g]=1.
    - Next cycle: go to IDLE. If the master still holds cyc, it re-arbitrates normally.
- Watchdog:
  - Counter cleared on every s_ack or s_err, and while no strobe is outstanding.
  - An outstanding strobe means s_stb=1 and s_stall=0 was seen, until the matching ack/err arrives. Outstanding accesses are tracked with a counter, max 2^4-1.
  - Counter increments each cycle at least one access is outstanding.
  - When counter == TIMEOUT_CYCLES, go to ABORT.
- Simultaneous events:
  - s_ack on the same cycle the watchdog would fire: the ack wins and the counter clears.
  - Master drops cyc on the same cycle as s_ack: the ack is still delivered (combinational), then the FSM goes to IDLE.
  - Any slave ack/err arriving in IDLE is discarded and not forwarded.
- Reset mid-cycle: outputs return to reset values immediately (async). The slave sees s_cyc fall; no err is generated.
- Masters with cyc=0 are never granted. stb without cyc is ignored.

Decomposition:
- Shared package wb_arb_pkg:
  - state enum (IDLE, GRANT, ABORT).
  - localparam IDX_W = $clog2(NUM_MASTERS).
  - OUTSTANDING_W = 4.
- Sub-module rr_picker (combinational): inputs req vector and last pointer; outputs valid and winner index. Reusable by other arbiters.

Test Plan:
- Single master 0 writes 0xDEADBEEF to 0x10; slave acks after 2 cycles -> s_addr=0x10, s_wdata=0xDEADBEEF, m_ack[0] one pulse, grant_idx=0, busy falls after cyc drops.
- Masters 0 and 1 raise cyc in the same cycle, three rounds -> grant order 0,1,0,1,0,1. The loser sees stall=1 and ack=0 throughout.
- Master 1 reads 0x20 while master 0 holds the grant -> master 1 waits. After master 0 releases, one idle cycle, then master 1 is granted and receives m_rdata=slave value with m_ack[1].
- Slave never acks, TIMEOUT_CYCLES=8 -> 8 cycles after acceptance, s_cyc=0 and m_err[g]=1 for one cycle, FSM back in IDLE.
- s_ack arrives on the exact cycle the counter reaches 8 -> m_ack asserted, no m_err, no ABORT.
- rst asserted mid-GRANT with stb outstanding -> s_cyc=0, m_stall all ones, grant_idx=0 in the same cycle. After release, master 0 wins the first contested arbitration.
